bus_timer: RTL and testbench

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/xoro_bus_pkg.sv | 36 +++
 rtl/bus_timer_prescaler.sv | 29 ++
 rtl/bus_timer.sv | 188 ++++++++++++++++++
 tb/tb_bus_timer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xoro_bus_pkg.sv
// Shared register map, CONTROL/STATUS bit positions, handshake state type and
// byte-strobe merge helper for the xoro bus peripherals.
package xoro_bus_pkg;

  localparam logic [1:0] REG_COUNT   = 2'd0;
  localparam logic [1:0] REG_COMPARE = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_RUN          = 0;
  localparam int CTRL_AUTORELOAD   = 1;
  localparam int CTRL_IRQEN        = 2;
  localparam int CTRL_PRESCALE_LSB = 16;
  localparam int STAT_MATCH        = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) begin
        res[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Tick divider for bus_timer: one tick every (prescale+1) cycles while run is
// high; the phase restarts whenever run is low or clear is pulsed.
module bus_timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div_r;

  assign tick = run && (div_r == prescale);

  // Divider phase counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= '0;
    end else if (!run || clear || tick) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer with compare match, autoreload and level irq.
// Optional tick prescaler enabled by defining BUS_TIMER_PRESCALER_EN.
module bus_timer
  import xoro_bus_pkg::*;
#(
  parameter int          PRESCALE_W    = 16,
  parameter logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  bus_state_e            state_r;
  logic [31:0]           count_r;
  logic [31:0]           compare_r;
  logic                  run_r;
  logic                  autoreload_r;
  logic                  irqen_r;
  logic                  match_r;
  logic [PRESCALE_W-1:0] prescale_s;
  logic                  tick_s;
  logic                  accept_s;
  logic                  wr_s;
  logic                  wr_count_s;
  logic                  wr_compare_s;
  logic                  wr_control_s;
  logic                  wr_status_s;
  logic [31:0]           ctrl_rd_s;
  logic [31:0]           ctrl_new_s;
  logic [31:0]           read_s;
  logic [31:0]           count_inc_s;
  logic                  match_set_s;
  logic                  unused_s;

  assign accept_s    = (state_r == ST_IDLE) && mem_valid && enable;
  assign wr_s        = accept_s && (mem_wstrb != 4'b0000);
  assign ctrl_new_s  = apply_wstrb(ctrl_rd_s, mem_wdata, mem_wstrb);
  assign count_inc_s = count_r + 32'd1;
  // A COUNT write replaces the tick entirely, so it also suppresses the match.
  assign match_set_s = tick_s && !wr_count_s && (count_inc_s == compare_r);
  assign irq         = match_r & irqen_r;

`ifdef BUS_TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale_r;

  // Prescale divider field of CONTROL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_r <= '0;
    end else if (wr_control_s) begin
      prescale_r <= ctrl_new_s[CTRL_PRESCALE_LSB +: PRESCALE_W];
    end
  end

  assign prescale_s = prescale_r;
  assign unused_s   = ^{mem_addr[31:4], mem_addr[1:0], ctrl_new_s[15:3]};

  bus_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .run      (run_r),
    .clear    (wr_control_s),
    .prescale (prescale_r),
    .tick     (tick_s)
  );
`else
  assign prescale_s = '0;
  assign tick_s     = run_r;
  assign unused_s   = ^{mem_addr[31:4], mem_addr[1:0], ctrl_new_s[31:3]};
`endif

  // Write decode and CONTROL readback image
  always_comb begin
    wr_count_s   = 1'b0;
    wr_compare_s = 1'b0;
    wr_control_s = 1'b0;
    wr_status_s  = 1'b0;
    ctrl_rd_s    = 32'd0;
    ctrl_rd_s[CTRL_RUN]        = run_r;
    ctrl_rd_s[CTRL_AUTORELOAD] = autoreload_r;
    ctrl_rd_s[CTRL_IRQEN]      = irqen_r;
    ctrl_rd_s[CTRL_PRESCALE_LSB +: PRESCALE_W] = prescale_s;
    if (wr_s) begin
      case (mem_addr[3:2])
        REG_COUNT:   wr_count_s   = 1'b1;
        REG_COMPARE: wr_compare_s = 1'b1;
        REG_CONTROL: wr_control_s = 1'b1;
        REG_STATUS:  wr_status_s  = 1'b1;
        default:     wr_count_s   = 1'b0;
      endcase
    end else begin
      wr_count_s = 1'b0;
    end
  end

  // Read mux over the register map
  always_comb begin
    read_s = 32'd0;
    case (mem_addr[3:2])
      REG_COUNT:   read_s = count_r;
      REG_COMPARE: read_s = compare_r;
      REG_CONTROL: read_s = ctrl_rd_s;
      REG_STATUS:  read_s[STAT_MATCH] = match_r;
      default:     read_s = 32'd0;
    endcase
  end

  // Handshake FSM with registered ready and read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_ACK;
            mem_ready <= 1'b1;
            mem_rdata <= wr_s ? 32'd0 : read_s;
          end else begin
            state_r   <= ST_IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
          end
        end
        ST_ACK: begin
          state_r   <= ST_IDLE;
          mem_ready <= 1'b0;
          mem_rdata <= 32'd0;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_ready <= 1'b0;
          mem_rdata <= 32'd0;
        end
      endcase
    end
  end

  // Counter, compare, control and match state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r      <= 32'd0;
      compare_r    <= COMPARE_RESET;
      run_r        <= 1'b0;
      autoreload_r <= 1'b0;
      irqen_r      <= 1'b0;
      match_r      <= 1'b0;
    end else begin
      if (wr_count_s) begin
        count_r <= apply_wstrb(count_r, mem_wdata, mem_wstrb);
      end else if (match_set_s && autoreload_r) begin
        count_r <= 32'd0;
      end else if (tick_s) begin
        count_r <= count_inc_s;
      end

      if (wr_compare_s) begin
        compare_r <= apply_wstrb(compare_r, mem_wdata, mem_wstrb);
      end

      if (wr_control_s) begin
        run_r        <= ctrl_new_s[CTRL_RUN];
        autoreload_r <= ctrl_new_s[CTRL_AUTORELOAD];
        irqen_r      <= ctrl_new_s[CTRL_IRQEN];
      end

      // A new match outranks a simultaneous write-1-to-clear
      if (match_set_s) begin
        match_r <= 1'b1;
      end else if (wr_status_s && mem_wstrb[0] && mem_wdata[STAT_MATCH]) begin
        match_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: cycle-level behavioural model with a
// per-cycle compare process, directed literal checks and random bus traffic.
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bus_timer dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .irq       (irq)
  );

  // Behavioural model state
  logic [31:0] m_count, m_compare, m_rdata, m_rv, m_ctl, m_next;
  logic [15:0] m_pre, m_phase;
  logic        m_run, m_auto, m_irqen, m_match, m_ack, m_ready;
  logic        m_acc, m_wr, m_tick, m_hit;
  logic [1:0]  m_word;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] mask;
    mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (old_v & ~mask) | (wd & mask);
  endfunction

  function automatic logic [31:0] ctrl_word(input logic [15:0] pre, input logic ie,
                                            input logic au, input logic rn);
    return {pre, 13'd0, ie, au, rn};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count = 32'd0; m_compare = 32'hFFFF_FFFF; m_run = 1'b0; m_auto = 1'b0;
      m_irqen = 1'b0; m_pre = 16'd0; m_phase = 16'd0; m_match = 1'b0;
      m_ack = 1'b0; m_ready = 1'b0; m_rdata = 32'd0;
    end else begin
      m_acc  = !m_ack && mem_valid && enable;
      m_wr   = m_acc && (mem_wstrb != 4'd0);
      m_word = mem_addr[3:2];
`ifdef BUS_TIMER_PRESCALER_EN
      m_tick = m_run && (m_phase == m_pre);
`else
      m_tick = m_run;
`endif
      case (m_word)
        2'd0:    m_rv = m_count;
        2'd1:    m_rv = m_compare;
        2'd2:    m_rv = ctrl_word(m_pre, m_irqen, m_auto, m_run);
        default: m_rv = {31'd0, m_match};
      endcase
      m_hit  = 1'b0;
      m_next = m_count;
      if (m_wr && m_word == 2'd0) m_next = merge(m_count, mem_wdata, mem_wstrb);
      else if (m_tick) begin
        m_next = m_count + 32'd1;
        if (m_next == m_compare) begin
          m_hit = 1'b1;
          if (m_auto) m_next = 32'd0;
        end
      end
      if (!m_run || (m_wr && m_word == 2'd2) || m_tick) m_phase = 16'd0;
      else m_phase = m_phase + 16'd1;
      if (m_hit) m_match = 1'b1;
      else if (m_wr && m_word == 2'd3 && mem_wstrb[0] && mem_wdata[0]) m_match = 1'b0;
      if (m_wr && m_word == 2'd1) m_compare = merge(m_compare, mem_wdata, mem_wstrb);
      if (m_wr && m_word == 2'd2) begin
        m_ctl   = merge(ctrl_word(m_pre, m_irqen, m_auto, m_run), mem_wdata, mem_wstrb);
        m_run   = m_ctl[0];
        m_auto  = m_ctl[1];
        m_irqen = m_ctl[2];
`ifdef BUS_TIMER_PRESCALER_EN
        m_pre   = m_ctl[31:16];
`else
        m_pre   = 16'd0;
`endif
      end
      m_count = m_next;
      m_ready = m_acc;
      m_rdata = (m_acc && !m_wr) ? m_rv : 32'd0;
      m_ack   = m_acc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'd0, mem_ready}, {31'd0, m_ready});
      check("rdata", mem_rdata, m_rdata);
      check("irq", {31'd0, irq}, {31'd0, m_match & m_irqen});
    end
  end

  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] st, output logic [31:0] rd,
                            output logic r1, output logic r2);
    enable = 1'b1; mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = st;
    @(posedge clk);
    @(negedge clk);
    rd = mem_rdata; r1 = mem_ready;
    enable = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0;
    @(posedge clk);
    @(negedge clk);
    r2 = mem_ready;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] rd;
    logic r1, r2;
    bus_access(addr, wd, st, rd, r1, r2);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic r1, r2;
    bus_access(addr, 32'd0, 4'd0, rd, r1, r2);
    check(name, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic r1, r2;
    logic [1:0] w;
    reset = 1'b1; enable = 1'b0; mem_valid = 1'b0;
    mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Read handshake on CONTROL right after reset
    bus_access(32'h8, 32'd0, 4'd0, rd, r1, r2);
    check("hs_ready_on", {31'd0, r1}, 32'd1);
    check("hs_rdata", rd, 32'd0);
    check("hs_ready_off", {31'd0, r2}, 32'd0);
    rd_check("rst_count", 32'h0, 32'd0);
    rd_check("rst_compare", 32'h4, 32'hFFFF_FFFF);
    rd_check("rst_status", 32'hC, 32'd0);

    // Byte write into COMPARE
    wr(32'h4, 32'hFFFF_FFFF, 4'hF);
    wr(32'h4, 32'h1234_5678, 4'b0010);
    rd_check("byte_write", 32'h4, 32'hFFFF_56FF);

    // Match with autoreload
    wr(32'h0, 32'd0, 4'hF);
    wr(32'h4, 32'd5, 4'hF);
    wr(32'h8, 32'h7, 4'hF);
    rd_check("reload_cnt1", 32'h0, 32'd1);
    @(posedge clk); @(negedge clk);
    check("irq_before", {31'd0, irq}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("irq_match", {31'd0, irq}, 32'd1);
    rd_check("reload_zero", 32'h0, 32'd0);
    wr(32'hC, 32'h1, 4'hF);
    check("irq_w1c", {31'd0, irq}, 32'd0);
    wr(32'h8, 32'h0, 4'hF);
    wr(32'hC, 32'h1, 4'hF);

    // COUNT write beats the tick on the same edge
    wr(32'h4, 32'h200, 4'hF);
    wr(32'h8, 32'h1, 4'hF);
    wr(32'h0, 32'h100, 4'hF);
    rd_check("cnt_write_prio", 32'h0, 32'h101);
    wr(32'h8, 32'h0, 4'hF);

    // Match set beats a simultaneous W1C
    wr(32'h0, 32'd0, 4'hF);
    wr(32'h4, 32'd2, 4'hF);
    wr(32'h8, 32'h1, 4'hF);
    wr(32'hC, 32'h1, 4'hF);
    wr(32'h8, 32'h0, 4'hF);
    rd_check("match_prio", 32'hC, 32'd1);
    wr(32'hC, 32'h1, 4'hF);

    // Wrap without flag
    wr(32'h4, 32'd7, 4'hF);
    wr(32'h0, 32'hFFFF_FFFF, 4'hF);
    wr(32'h8, 32'h1, 4'hF);
    rd_check("wrap_status", 32'hC, 32'd0);
    rd_check("wrap_count", 32'h0, 32'd2);
    wr(32'h8, 32'h0, 4'hF);

    // Prescale field
    wr(32'h8, 32'h0003_0001, 4'hF);
`ifdef BUS_TIMER_PRESCALER_EN
    rd_check("ctrl_prescale", 32'h8, 32'h0003_0001);
`else
    rd_check("ctrl_prescale", 32'h8, 32'h0000_0001);
`endif
    repeat (12) @(negedge clk);
    wr(32'h8, 32'h0, 4'hF);

    // Reset during ACK aborts the access
    enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h4; mem_wdata = 32'h55; mem_wstrb = 4'hF;
    @(posedge clk);
    #2;
    reset = 1'b1;
    enable = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0;
    @(negedge clk);
    check("abort_ready", {31'd0, mem_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    rd_check("abort_count", 32'h0, 32'd0);
    rd_check("abort_compare", 32'h4, 32'hFFFF_FFFF);
    rd_check("abort_control", 32'h8, 32'd0);
    rd_check("abort_status", 32'hC, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      w = 2'($urandom_range(0, 3));
      enable    = ($urandom_range(0, 9) < 8);
      mem_valid = ($urandom_range(0, 9) < 6);
      mem_addr  = {$urandom() & 32'hFFFF_FFF0} | {28'd0, w, 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 3))
        0, 1:    mem_wstrb = 4'd0;
        2:       mem_wstrb = 4'hF;
        default: mem_wstrb = 4'($urandom_range(1, 15));
      endcase
      case (w)
        2'd0: mem_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                      : 32'($urandom_range(0, 40));
        2'd1: mem_wdata = 32'($urandom_range(1, 40));
        2'd2: mem_wdata = {16'($urandom_range(0, 3)), 13'd0, 2'($urandom_range(0, 3)),
                           ($urandom_range(0, 3) != 0)};
        default: mem_wdata = $urandom();
      endcase
      @(negedge clk);
    end
    enable = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
